turn_lane_car_dispatcher: RTL and testbench
===========================================

// Module: turn_lane_car_dispatcher
// PURPOSE
//  Producer end of the add_car/decrement_car interface of the left-turn animators.
//  Holds the count of cars waiting in the turn lane and requests one car launch at a time while the turn light is green.
//  Retires a waiting car on each decrement_car acknowledge.
//  Sits between the lane sensor/button logic and one turn animator instance.
// PARAMETERS
//  MAX_CARS   7   queue capacity; queue_count saturates here
//  CW         3   queue_count width; must satisfy 2**CW > MAX_CARS
//  GAP_CYCLES 4   idle cycles after each ack before the next request (car headway)
//  ACK_TMO    8   cycles in REQ without ack before proto_err is raised
// PORTS
//  traffic_clk    in   1   traffic tick clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  car_arrive     in   1   1-cycle pulse: a car joins the turn lane
//  turn_green     in   1   level: left-turn arrow is green
//  decrement_car  in   1   1-cycle ack from the animator: car launched
//  add_car        out  1   level request to the animator to launch a car
//  queue_count    out  CW  cars waiting, 0..MAX_CARS
//  queue_empty    out  1   queue_count == 0
//  queue_full     out  1   queue_count == MAX_CARS
//  car_lost       out  1   1-cycle pulse: an arrival was dropped because the queue was full
//  proto_err      out  1   sticky: ack timeout, or ack received outside REQ
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, queue_count=0, add_car=0, car_lost=0, proto_err=0.
//    queue_empty=1, queue_full=0.
//  FSM states: IDLE, REQ, GAP. add_car = (state==REQ), registered with no combinational path from inputs.
//  IDLE -> REQ when turn_green && !queue_empty; otherwise stay in IDLE.
//  REQ:
//   - decrement_car=1: queue_count-1, go to GAP, load gap counter with GAP_CYCLES-1.
//   - else turn_green=0: abort request, go to IDLE, count unchanged.
//     Ack has priority over an abort in the same cycle.
//   - else the timeout counter increments; at ACK_TMO-1 set proto_err and stay in REQ.
//     The timeout counter saturates there.
//  GAP: count down to 0, then go to IDLE. turn_green is ignored during GAP.
//  Launch timing: the animator samples add_car and acks 1 cycle later.
//   - add_car drops on the edge after decrement_car.
//   - The minimum period between consecutive acks is GAP_CYCLES+3 cycles.
//  Count arithmetic, with inc = car_arrive && (!full || dec) and dec = ack accepted in REQ:
//   - inc && !dec: +1.  dec && !inc: -1.  Both: unchanged.
//   - Arrival while full with no ack in the same cycle: count held, car_lost=1 next cycle.
//   - Count never wraps in either direction.
//  decrement_car while not in REQ: ignored for counting, proto_err set.
//  proto_err is cleared only by reset.
//  Reset mid-REQ: add_car drops asynchronously, any in-flight launch is forgotten, queue_count=0.
// STRUCTURE
//  traffic_pkg holds:
//   - typedef enum logic [1:0] {IDLE, REQ, GAP} disp_state_t;
//   - shared constants for the MAX_CARS, GAP_CYCLES and ACK_TMO defaults.
//  Sub-module car_queue_counter (parameters MAX_CARS and CW):
//   - ports inc, dec -> count, empty, full, lost.
//   - owns the saturation and drop rules.
//  The top level holds the FSM, the gap counter and the timeout counter.
// TESTING
//  1. After reset: 3 arrive pulses with turn_green=0 -> queue_count=3, add_car=0 throughout.
//  2. turn_green=1 with the real animator instance -> 3 launches.
//     Acks spaced GAP_CYCLES+3 apart; queue_count goes 2,1,0; then IDLE with queue_empty=1.
//  3. 8 arrivals with MAX_CARS=7 -> queue_count=7, queue_full=1, exactly one car_lost pulse.
//  4. Arrival in the same cycle as an ack at count=7 -> count stays 7, no car_lost.
//  5. turn_green drops while in REQ with no ack -> add_car=0 next cycle, count unchanged.
//     Green returns -> new request.
//  6. Stub animator never acks -> proto_err=1 after 8 cycles in REQ.
//     Assert reset mid-REQ -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and default sizing for the turn-lane dispatcher.
package traffic_pkg;

  typedef enum logic [1:0] {IDLE, REQ, GAP} disp_state_t;

  localparam int MAX_CARS_DEF   = 7;
  localparam int CW_DEF         = 3;
  localparam int GAP_CYCLES_DEF = 4;
  localparam int ACK_TMO_DEF    = 8;

endpackage

// File: rtl/turn_lane_car_dispatcher_queue.sv
// Saturating count of cars waiting in the turn lane, with drop reporting.
module car_queue_counter
  import traffic_pkg::*;
#(
  parameter int MAX_CARS = MAX_CARS_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          traffic_clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          lost
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CARS);

  logic [CW-1:0] cnt;
  logic          dec_ok;
  logic          inc_ok;

  // A departure frees a slot, so an arrival in the same cycle is still accepted.
  assign dec_ok = dec && (cnt != '0);
  assign inc_ok = inc && ((cnt != MAX_C) || dec_ok);

  // Count update and one-cycle drop pulse.
  always_ff @(posedge traffic_clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      lost <= 1'b0;
    end else begin
      lost <= inc && !inc_ok;
      case ({inc_ok, dec_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == MAX_C);

endmodule

// File: rtl/turn_lane_car_dispatcher.sv
// Requests one car launch at a time from a turn animator while the arrow is green.
module turn_lane_car_dispatcher
  import traffic_pkg::*;
#(
  parameter int MAX_CARS   = MAX_CARS_DEF,
  parameter int CW         = CW_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int ACK_TMO    = ACK_TMO_DEF
) (
  input  logic          traffic_clk,
  input  logic          reset,
  input  logic          car_arrive,
  input  logic          turn_green,
  input  logic          decrement_car,
  output logic          add_car,
  output logic [CW-1:0] queue_count,
  output logic          queue_empty,
  output logic          queue_full,
  output logic          car_lost,
  output logic          proto_err
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(ACK_TMO + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(ACK_TMO - 1);

  disp_state_t   state, state_nx;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          ack_ok;
  logic          tmo_hit;

  assign ack_ok  = (state == REQ) && decrement_car;
  assign tmo_hit = (state == REQ) && !decrement_car && turn_green && (tmo_cnt == TMO_MAX);

  car_queue_counter #(.MAX_CARS(MAX_CARS), .CW(CW)) u_queue (
    .traffic_clk (traffic_clk),
    .reset       (reset),
    .inc         (car_arrive),
    .dec         (ack_ok),
    .count       (queue_count),
    .empty       (queue_empty),
    .full        (queue_full),
    .lost        (car_lost)
  );

  // State register.
  always_ff @(posedge traffic_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: ack beats abort in REQ; green is ignored during the headway gap.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (turn_green && !queue_empty) state_nx = REQ;
      REQ: begin
        if (decrement_car)    state_nx = GAP;
        else if (!turn_green) state_nx = IDLE;
      end
      GAP: if (gap_cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Headway counter: loaded on ack, counts down through GAP.
  always_ff @(posedge traffic_clk or negedge reset) begin
    if (!reset)                          gap_cnt <= '0;
    else if (ack_ok)                     gap_cnt <= GAP_LOAD;
    else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
  end

  // Ack timeout counter: runs only while waiting in REQ, saturates at the limit.
  always_ff @(posedge traffic_clk or negedge reset) begin
    if (!reset)                                       tmo_cnt <= '0;
    else if (state != REQ || decrement_car || !turn_green) tmo_cnt <= '0;
    else if (tmo_cnt != TMO_MAX)                      tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Sticky protocol error: stray ack outside REQ, or ack never arrived.
  always_ff @(posedge traffic_clk or negedge reset) begin
    if (!reset) proto_err <= 1'b0;
    else if ((decrement_car && state != REQ) || tmo_hit) proto_err <= 1'b1;
  end

  assign add_car = (state == REQ);

endmodule

// File: tb/tb_turn_lane_car_dispatcher.sv
// Scoreboarded bench for the turn-lane dispatcher with a behavioural animator.
module tb_turn_lane_car_dispatcher;

  localparam int GAP_CYCLES = 4;

  logic       traffic_clk = 1'b0;
  logic       reset = 1'b0;
  logic       car_arrive = 1'b0;
  logic       turn_green = 1'b0;
  logic       decrement_car = 1'b0;
  logic       add_car;
  logic [2:0] queue_count;
  logic       queue_empty;
  logic       queue_full;
  logic       car_lost;
  logic       proto_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_ack = -1;
  int lost_seen = 0;
  bit anim_en = 0;
  bit chk_gap = 0;
  int exp_q[$];

  turn_lane_car_dispatcher dut (
    .traffic_clk   (traffic_clk),
    .reset         (reset),
    .car_arrive    (car_arrive),
    .turn_green    (turn_green),
    .decrement_car (decrement_car),
    .add_car       (add_car),
    .queue_count   (queue_count),
    .queue_empty   (queue_empty),
    .queue_full    (queue_full),
    .car_lost      (car_lost),
    .proto_err     (proto_err)
  );

  always #5 traffic_clk = ~traffic_clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock; the animator acks one cycle after it samples add_car high.
  task automatic tick();
    logic a, d;
    a = add_car;
    d = decrement_car;
    @(posedge traffic_clk);
    #1;
    cyc++;
    if (a && d) begin
      if (exp_q.size() == 0) chk("unexpected_ack", exp_q.size(), 1);
      else                   chk("ack_count", queue_count, exp_q.pop_front());
      if (chk_gap && last_ack >= 0) chk("ack_gap", cyc - last_ack, GAP_CYCLES + 3);
      last_ack = cyc;
    end
    decrement_car = anim_en && a && !d;
    lost_seen += car_lost;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_add"},   add_car, 0);
    chk({tag, "_count"}, queue_count, 0);
    chk({tag, "_empty"}, queue_empty, 1);
    chk({tag, "_full"},  queue_full, 0);
    chk({tag, "_lost"},  car_lost, 0);
    chk({tag, "_err"},   proto_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge traffic_clk);
    #1;
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // 1: arrivals with red arrow queue up, no request
    for (int i = 0; i < 3; i++) begin
      car_arrive = 1'b1;
      tick();
      car_arrive = 1'b0;
      chk("t1_no_req", add_car, 0);
      tick();
      chk("t1_no_req", add_car, 0);
    end
    chk("t1_count", queue_count, 3);

    // 2: green with animator -> three launches at minimum headway
    exp_q.push_back(2);
    exp_q.push_back(1);
    exp_q.push_back(0);
    anim_en = 1;
    chk_gap = 1;
    last_ack = -1;
    turn_green = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk("t2_launches_done", exp_q.size(), 0);
    repeat (8) tick();
    chk("t2_empty", queue_empty, 1);
    chk("t2_idle", add_car, 0);
    turn_green = 1'b0;
    chk_gap = 0;
    anim_en = 0;

    // 3: eight arrivals saturate at seven with one drop
    lost_seen = 0;
    car_arrive = 1'b1;
    repeat (8) tick();
    car_arrive = 1'b0;
    chk("t3_lost_pulse", car_lost, 1);
    tick();
    chk("t3_lost_clear", car_lost, 0);
    chk("t3_count", queue_count, 7);
    chk("t3_full", queue_full, 1);
    chk("t3_lost_total", lost_seen, 1);

    // 4: arrival together with ack at full -> accepted, stays 7
    anim_en = 1;
    turn_green = 1'b1;
    for (int i = 0; i < 10 && !decrement_car; i++) tick();
    chk("t4_ack_seen", decrement_car, 1);
    car_arrive = 1'b1;
    exp_q.push_back(7);
    tick();
    car_arrive = 1'b0;
    chk("t4_no_lost", car_lost, 0);
    chk("t4_count", queue_count, 7);
    turn_green = 1'b0;
    anim_en = 0;
    repeat (6) tick();
    chk("t4_sb_drained", exp_q.size(), 0);

    // 5: green drops in REQ without ack -> abort, then re-request
    turn_green = 1'b1;
    tick();
    chk("t5_req", add_car, 1);
    tick();
    turn_green = 1'b0;
    tick();
    chk("t5_abort", add_car, 0);
    chk("t5_count", queue_count, 7);
    turn_green = 1'b1;
    tick();
    chk("t5_rereq", add_car, 1);

    // 6: stub never acks -> timeout after 8 REQ cycles, then async reset
    repeat (7) tick();
    chk("t6_err_early", proto_err, 0);
    tick();
    chk("t6_err_set", proto_err, 1);
    chk("t6_still_req", add_car, 1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    turn_green = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    chk("t6_post_count", queue_count, 0);
    chk("t6_post_add", add_car, 0);

    // Stray ack outside REQ flags an error without touching the count
    decrement_car = 1'b1;
    tick();
    chk("stray_err", proto_err, 1);
    chk("stray_count", queue_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
